pooling_stream: RTL and testbench

//  Streaming POOLxPOOL, stride-POOL pooling for CNN feature maps, UNITS channels in parallel.

---
 rtl/pooling_stream.sv | 206 ++++++++++++++++++++
 tb/tb_pooling_stream.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pooling_stream.sv
// Streaming POOLxPOOL, stride-POOL pooling (signed max or floor average) over UNITS parallel channels.
// Three register stages: input capture, horizontal/row-buffer combine, final select/divide.
module pooling_stream #(
  parameter int WIDTH      = 4,
  parameter int HEIGHT     = 4,
  parameter int W_WIDTH    = 6,
  parameter int W_HEIGHT   = 5,
  parameter int FIXED_BITW = 8,
  parameter int UNITS      = 1,
  parameter int POOL       = 2,
  parameter int MODE       = 0,
  localparam int H_BITW    = $clog2(W_WIDTH),
  localparam int V_BITW    = $clog2(W_HEIGHT),
  localparam int P_BITW    = $clog2(POOL)
) (
  input  logic                          clock,
  input  logic                          n_rst,
  input  logic                          in_enable,
  input  logic [FIXED_BITW*UNITS-1:0]   in_pixels,
  input  logic [V_BITW-1:0]             in_vcnt,
  input  logic [H_BITW-1:0]             in_hcnt,
  output logic                          out_enable,
  output logic [FIXED_BITW*UNITS-1:0]   out_pixels,
  output logic [V_BITW-P_BITW-1:0]      out_vcnt,
  output logic [H_BITW-P_BITW-1:0]      out_hcnt
);
  localparam int ACC_W = (MODE == 1) ? FIXED_BITW + 2*P_BITW : FIXED_BITW;
  localparam int NCOL  = WIDTH / POOL;
  localparam int NROW  = HEIGHT / POOL;
  localparam int CI_W  = (NCOL > 1) ? $clog2(NCOL) : 1;
  localparam int CO_W  = H_BITW - P_BITW;
  localparam int RO_W  = V_BITW - P_BITW;
  localparam int RC_W  = P_BITW + 1;
  localparam logic [P_BITW-1:0] PH_LAST = P_BITW'(POOL - 1);

  function automatic logic signed [ACC_W-1:0] combine(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] b);
    if (MODE == 1) return a + b;
    return (a > b) ? a : b;
  endfunction

  function automatic logic signed [ACC_W-1:0] widen(input logic signed [FIXED_BITW-1:0] p);
    return ACC_W'(p);
  endfunction

  function automatic logic [FIXED_BITW-1:0] scale(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] s;
    s = (MODE == 1) ? (v >>> (2*P_BITW)) : v;
    return s[FIXED_BITW-1:0];
  endfunction

  // Stage 1: only pixels inside a complete window are taken; partial columns/lines never reach state.
  logic [CO_W-1:0] in_col;
  logic [RO_W-1:0] in_row;
  logic            in_accept;

  assign in_col    = in_hcnt[H_BITW-1:P_BITW];
  assign in_row    = in_vcnt[V_BITW-1:P_BITW];
  assign in_accept = in_enable
                  && ({1'b0, in_col} < (CO_W+1)'(NCOL))
                  && ({1'b0, in_row} < (RO_W+1)'(NROW));

  logic                        s1_valid_q;
  logic [FIXED_BITW*UNITS-1:0] s1_pix_q;
  logic [P_BITW-1:0]           s1_hp_q;
  logic [P_BITW-1:0]           s1_vp_q;
  logic [CI_W-1:0]             s1_col_q;
  logic [RO_W-1:0]             s1_row_q;

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      s1_valid_q <= 1'b0;
      s1_pix_q   <= '0;
      s1_hp_q    <= '0;
      s1_vp_q    <= '0;
      s1_col_q   <= '0;
      s1_row_q   <= '0;
    end else begin
      s1_valid_q <= in_accept;
      if (in_accept) begin
        s1_pix_q <= in_pixels;
        s1_hp_q  <= in_hcnt[P_BITW-1:0];
        s1_vp_q  <= in_vcnt[P_BITW-1:0];
        s1_col_q <= CI_W'(in_col);
        s1_row_q <= in_row;
      end
    end
  end

  // Stage 2: horizontal accumulator plus per-column row-partial buffer and row counters.
  logic [UNITS*ACC_W-1:0] acc_q, acc_d;
  logic                   hflag_q, hflag_d;
  logic [UNITS*ACC_W-1:0] rbuf_q [NCOL];
  logic [RC_W-1:0]        rows_q [NCOL];
  logic [UNITS*ACC_W-1:0] pix_w, hres, vres, row_rd, buf_d;
  logic [RC_W-1:0]        rows_cur, rows_d;
  logic                   rows_wr, buf_wr;
  logic                   s2_valid_q, s2_valid_d;
  logic [UNITS*ACC_W-1:0] s2_data_q;
  logic [CI_W-1:0]        s2_col_q;
  logic [RO_W-1:0]        s2_row_q;

  always_comb begin
    pix_w      = '0;
    hres       = '0;
    vres       = '0;
    row_rd     = rbuf_q[s1_col_q];
    rows_cur   = rows_q[s1_col_q];
    acc_d      = acc_q;
    hflag_d    = hflag_q;
    rows_wr    = 1'b0;
    rows_d     = '0;
    buf_wr     = 1'b0;
    buf_d      = '0;
    s2_valid_d = 1'b0;
    for (int unsigned u = 0; u < UNITS; u++) begin
      pix_w[u*ACC_W +: ACC_W] = widen(s1_pix_q[u*FIXED_BITW +: FIXED_BITW]);
      hres[u*ACC_W +: ACC_W]  = combine(acc_q[u*ACC_W +: ACC_W], pix_w[u*ACC_W +: ACC_W]);
      vres[u*ACC_W +: ACC_W]  = combine(row_rd[u*ACC_W +: ACC_W], hres[u*ACC_W +: ACC_W]);
    end
    if (s1_valid_q) begin
      if (s1_hp_q == '0) begin
        acc_d   = pix_w;
        hflag_d = 1'b1;
      end else begin
        acc_d = hres;
      end
      // A window row only counts if its leading pixel was seen since reset (hflag).
      if (s1_hp_q == PH_LAST && hflag_q) begin
        buf_wr  = 1'b1;
        rows_wr = 1'b1;
        if (s1_vp_q == '0) begin
          buf_d  = hres;
          rows_d = RC_W'(1);
        end else begin
          buf_d = vres;
          if (rows_cur == {1'b0, s1_vp_q}) begin
            if (s1_vp_q == PH_LAST) s2_valid_d = 1'b1;
            else                    rows_d = rows_cur + RC_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      acc_q      <= '0;
      hflag_q    <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_col_q   <= '0;
      s2_row_q   <= '0;
      for (int unsigned c = 0; c < NCOL; c++) rows_q[c] <= '0;
    end else begin
      acc_q      <= acc_d;
      hflag_q    <= hflag_d;
      s2_valid_q <= s2_valid_d;
      if (rows_wr) rows_q[s1_col_q] <= rows_d;
      if (s2_valid_d) begin
        s2_data_q <= vres;
        s2_col_q  <= s1_col_q;
        s2_row_q  <= s1_row_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (buf_wr) rbuf_q[s1_col_q] <= buf_d;
  end

  // Stage 3: divide/select into held output registers.
  logic [FIXED_BITW*UNITS-1:0] res_d;
  logic                        out_enable_q;
  logic [FIXED_BITW*UNITS-1:0] out_pixels_q;
  logic [RO_W-1:0]             out_vcnt_q;
  logic [CO_W-1:0]             out_hcnt_q;

  always_comb begin
    res_d = '0;
    for (int unsigned u = 0; u < UNITS; u++)
      res_d[u*FIXED_BITW +: FIXED_BITW] = scale(s2_data_q[u*ACC_W +: ACC_W]);
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      out_enable_q <= 1'b0;
      out_pixels_q <= '0;
      out_vcnt_q   <= '0;
      out_hcnt_q   <= '0;
    end else begin
      out_enable_q <= s2_valid_q;
      if (s2_valid_q) begin
        out_pixels_q <= res_d;
        out_vcnt_q   <= s2_row_q;
        out_hcnt_q   <= CO_W'(s2_col_q);
      end
    end
  end

  assign out_enable = out_enable_q;
  assign out_pixels = out_pixels_q;
  assign out_vcnt   = out_vcnt_q;
  assign out_hcnt   = out_hcnt_q;

endmodule

// File: tb/tb_pooling_stream.sv
// Directed bench for pooling_stream: max (2 ch), average, and partial-window configurations.
module tb_pooling_stream;
  logic clock = 1'b0;
  logic n_rst = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // A: MODE0, 2 channels, 4x4 in 6x5.  B: MODE1, 4x4 in 6x5.  C: MODE0, 5x5 in 7x6.
  logic        a_en, b_en, c_en;
  logic [15:0] a_pix;
  logic [7:0]  b_pix, c_pix;
  logic [2:0]  a_v, a_h, b_v, b_h, c_v, c_h;
  logic        a_oen, b_oen, c_oen;
  logic [15:0] a_opix;
  logic [7:0]  b_opix, c_opix;
  logic [1:0]  a_ov, a_oh, b_ov, b_oh, c_ov, c_oh;

  pooling_stream #(.WIDTH(4), .HEIGHT(4), .W_WIDTH(6), .W_HEIGHT(5), .FIXED_BITW(8),
                   .UNITS(2), .POOL(2), .MODE(0)) u_a (
    .clock(clock), .n_rst(n_rst), .in_enable(a_en), .in_pixels(a_pix), .in_vcnt(a_v),
    .in_hcnt(a_h), .out_enable(a_oen), .out_pixels(a_opix), .out_vcnt(a_ov), .out_hcnt(a_oh));

  pooling_stream #(.WIDTH(4), .HEIGHT(4), .W_WIDTH(6), .W_HEIGHT(5), .FIXED_BITW(8),
                   .UNITS(1), .POOL(2), .MODE(1)) u_b (
    .clock(clock), .n_rst(n_rst), .in_enable(b_en), .in_pixels(b_pix), .in_vcnt(b_v),
    .in_hcnt(b_h), .out_enable(b_oen), .out_pixels(b_opix), .out_vcnt(b_ov), .out_hcnt(b_oh));

  pooling_stream #(.WIDTH(5), .HEIGHT(5), .W_WIDTH(7), .W_HEIGHT(6), .FIXED_BITW(8),
                   .UNITS(1), .POOL(2), .MODE(0)) u_c (
    .clock(clock), .n_rst(n_rst), .in_enable(c_en), .in_pixels(c_pix), .in_vcnt(c_v),
    .in_hcnt(c_h), .out_enable(c_oen), .out_pixels(c_opix), .out_vcnt(c_ov), .out_hcnt(c_oh));

  typedef struct { int id; logic [15:0] pix; int v; int h; int cyc; } ev_t;
  ev_t qo[$];
  int  ecyc[$];
  int  fr0[7][7], fr1[7][7];
  int  ex0[4], ex1[4];
  int  errors = 0;
  int  checks = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int s8(input logic [7:0] x);
    return int'($signed(x));
  endfunction

  function automatic void push_ev(input int id, input logic [15:0] pix, input int v, input int h);
    ev_t e;
    e.id = id; e.pix = pix; e.v = v; e.h = h; e.cyc = cyc;
    qo.push_back(e);
  endfunction

  always @(negedge clock) begin
    if (a_oen) push_ev(0, a_opix, int'(a_ov), int'(a_oh));
    if (b_oen) push_ev(1, 16'(b_opix), int'(b_ov), int'(b_oh));
    if (c_oen) push_ev(2, 16'(c_opix), int'(c_ov), int'(c_oh));
  end

  task automatic put(input int sel, input bit en, input int v, input int h, input int p0, input int p1);
    a_en = 1'b0; b_en = 1'b0; c_en = 1'b0;
    case (sel)
      0: begin a_en = en; a_v = 3'(v); a_h = 3'(h); a_pix = {8'(p1), 8'(p0)}; end
      1: begin b_en = en; b_v = 3'(v); b_h = 3'(h); b_pix = 8'(p0); end
      default: begin c_en = en; c_v = 3'(v); c_h = 3'(h); c_pix = 8'(p0); end
    endcase
  endtask

  // Raster scan over the full frame incl. blanking; notes the cycle of each window's last pixel.
  task automatic drive(input int sel, input int v0, input int v1, input int ww, input int act, input bit gaps);
    for (int v = v0; v <= v1; v++) begin
      for (int h = 0; h < ww; h++) begin
        if (gaps) begin
          int g;
          g = int'($urandom_range(3));
          repeat (g) begin
            put(sel, 1'b0, int'($urandom_range(7)), int'($urandom_range(7)), int'($urandom), int'($urandom));
            @(negedge clock);
          end
        end
        put(sel, 1'b1, v, h, fr0[v][h], fr1[v][h]);
        if (v % 2 == 1 && h % 2 == 1 && v < (act / 2) * 2 && h < (act / 2) * 2) ecyc.push_back(cyc);
        @(negedge clock);
      end
    end
    put(sel, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic check_frame(input string tn, input int sel, input int first, input int n, input bit two);
    repeat (6) @(negedge clock);
    check({tn, ".count"}, qo.size(), n);
    for (int i = 0; i < n; i++) begin
      int k;
      k = first + i;
      if (i < qo.size() && i < ecyc.size()) begin
        check($sformatf("%s.w%0d.ch0", tn, k), s8(qo[i].pix[7:0]), ex0[k]);
        if (two) check($sformatf("%s.w%0d.ch1", tn, k), s8(qo[i].pix[15:8]), ex1[k]);
        check($sformatf("%s.w%0d.vcnt", tn, k), qo[i].v, k / 2);
        check($sformatf("%s.w%0d.hcnt", tn, k), qo[i].h, k % 2);
        check($sformatf("%s.w%0d.lat", tn, k), qo[i].cyc - ecyc[i], 3);
        check($sformatf("%s.w%0d.unit", tn, k), qo[i].id, sel);
      end
    end
    qo.delete();
    ecyc.delete();
  endtask

  task automatic fill_bg();
    for (int v = 0; v < 7; v++)
      for (int h = 0; h < 7; h++) begin
        fr0[v][h] = 120;
        fr1[v][h] = 120;
      end
  endtask

  task automatic set_win(input int ch, input int r, input int c, input int p00, input int p01,
                         input int p10, input int p11);
    if (ch == 0) begin
      fr0[2*r][2*c] = p00; fr0[2*r][2*c+1] = p01; fr0[2*r+1][2*c] = p10; fr0[2*r+1][2*c+1] = p11;
    end else begin
      fr1[2*r][2*c] = p00; fr1[2*r][2*c+1] = p01; fr1[2*r+1][2*c] = p10; fr1[2*r+1][2*c+1] = p11;
    end
  endtask

  task automatic fill_t1();
    fill_bg();
    for (int v = 0; v < 4; v++)
      for (int h = 0; h < 4; h++) begin
        fr0[v][h] = 4 * v + h;
        fr1[v][h] = -(4 * v + h);
      end
    ex0 = '{5, 7, 13, 15};
    ex1 = '{0, -2, -8, -10};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a_en = 1'b0; b_en = 1'b0; c_en = 1'b0;
    a_pix = '0; b_pix = '0; c_pix = '0;
    a_v = '0; a_h = '0; b_v = '0; b_h = '0; c_v = '0; c_h = '0;
    repeat (3) @(negedge clock);
    check("rst.a_en", int'(a_oen), 0);
    check("rst.a_pix", int'(a_opix), 0);
    check("rst.a_v", int'(a_ov), 0);
    check("rst.a_h", int'(a_oh), 0);
    check("rst.b_en", int'(b_oen), 0);
    check("rst.b_pix", int'(b_opix), 0);
    check("rst.c_en", int'(c_oen), 0);
    check("rst.c_pix", int'(c_opix), 0);
    n_rst = 1'b1;
    repeat (2) @(negedge clock);

    // Max over ramp frame, channel 1 is the negated ramp
    fill_t1();
    drive(0, 0, 4, 6, 4, 1'b0);
    check_frame("T1", 0, 0, 4, 1'b1);

    // Signed max corner values, two independent channels
    fill_bg();
    set_win(0, 0, 0, -128, -1, -5, -7);
    set_win(0, 0, 1, -128, -128, -128, -128);
    set_win(0, 1, 0, 127, -128, 0, 0);
    set_win(0, 1, 1, -2, -3, -4, -9);
    set_win(1, 0, 0, 7, 1, 5, -128);
    set_win(1, 0, 1, -128, -128, -128, -127);
    set_win(1, 1, 0, -127, -128, 0, 0);
    set_win(1, 1, 1, 2, 3, 4, 9);
    ex0 = '{-1, -128, 127, -2};
    ex1 = '{7, -127, 0, 9};
    drive(0, 0, 4, 6, 4, 1'b0);
    check_frame("T3", 0, 0, 4, 1'b1);

    // Floor average, including negative rounding and full-scale sums
    fill_bg();
    set_win(0, 0, 0, -3, -2, -1, 1);
    set_win(0, 0, 1, 127, 127, 127, 126);
    set_win(0, 1, 0, -128, -128, -128, -128);
    set_win(0, 1, 1, 5, 6, 7, 8);
    ex0 = '{-2, 126, -128, 6};
    drive(1, 0, 4, 6, 4, 1'b0);
    check_frame("T2", 1, 0, 4, 1'b0);

    // Odd active size: trailing column/line carry a large value that must never appear
    fill_bg();
    for (int v = 0; v < 4; v++)
      for (int h = 0; h < 4; h++) fr0[v][h] = 5 * v + h;
    ex0 = '{6, 8, 16, 18};
    drive(2, 0, 5, 7, 5, 1'b0);
    check_frame("T5", 2, 0, 4, 1'b0);

    // Same ramp frame with random enable gaps
    fill_t1();
    drive(0, 0, 4, 6, 4, 1'b1);
    check_frame("T4", 0, 0, 4, 1'b1);
    check("hold.en", int'(a_oen), 0);
    check("hold.ch0", s8(a_opix[7:0]), 15);
    check("hold.ch1", s8(a_opix[15:8]), -10);
    check("hold.v", int'(a_ov), 1);
    check("hold.h", int'(a_oh), 1);

    // Reset after line 0: outputs clear at once, window row 0 of this frame is lost
    drive(0, 0, 0, 6, 4, 1'b0);
    n_rst = 1'b0;
    #1;
    check("arst.en", int'(a_oen), 0);
    check("arst.pix", int'(a_opix), 0);
    check("arst.v", int'(a_ov), 0);
    check("arst.h", int'(a_oh), 0);
    repeat (2) @(negedge clock);
    n_rst = 1'b1;
    drive(0, 1, 4, 6, 4, 1'b0);
    void'(ecyc.pop_front());
    void'(ecyc.pop_front());
    check_frame("T6a", 0, 2, 2, 1'b1);
    drive(0, 0, 4, 6, 4, 1'b0);
    check_frame("T6b", 0, 0, 4, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
